lamp_cmd_demux16: RTL and testbench
===================================

Name: lamp_cmd_demux16

Overview:
- Receiving end of the switch/sensor selection path: takes a 4-bit lamp index plus a 2-bit command and applies it to one of 16 registered lamp outputs.
- Also supports a master broadcast that sweeps the same command across all 16 lamps, one lamp per clock.
- Sits downstream of the priority-encoder/mux selection logic and drives the lamp bank.

Parameters:
- N_LAMPS, 16, number of lamp outputs. Fixed at 16; other values are unsupported.
- IDX_W, 4, index width (log2 of N_LAMPS).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- valid  input  1  single-lamp command present this cycle.
- ready  output  1  block can accept a single-lamp command this cycle.
- idx  input  4  target lamp index; idx=0 is lamp 0, the highest-priority position.
- cmd  input  2  single-lamp command: 00 no-op, 01 off, 10 on, 11 toggle.
- bcast  input  1  one-cycle request to start a broadcast sweep.
- bcast_cmd  input  2  command applied to every lamp during the sweep; same encoding as cmd.
- lamps  output  16  registered lamp states; lamps[k] is lamp k.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse in the cycle after lamp 15 is written by a sweep.

Behaviour:
- One clock, one domain. reset is synchronous and active-high. On reset:
  - lamps=16'h0000, busy=0, done=0;
  - FSM to IDLE; sweep counter=0; latched broadcast command=00.
- Command semantics per lamp: 00 hold; 01 clear to 0; 10 set to 1; 11 invert.
- ready is combinational: ready = (state==IDLE) && !bcast.
- Single write:
  - Accepted when valid && ready. lamps[idx] updates on that same rising edge; visible the next cycle (1-cycle latency).
  - Only lamps[idx] changes; the other 15 lamps hold.
  - valid while ready=0: the command is dropped, not queued, and no state changes.
- FSM states: IDLE, SWEEP.
- IDLE -> SWEEP:
  - Triggered by bcast=1 in IDLE.
  - On that edge: latch bcast_cmd, set counter=0, set busy=1.
  - Any simultaneous valid is ignored, since ready=0 that cycle.
- SWEEP:
  - Each cycle apply the latched command to lamps[counter], then increment counter.
  - Lamp k is written on the (k+1)th edge after entry. Lamps not yet reached hold.
  - bcast, bcast_cmd, valid and cmd are all ignored while in SWEEP.
- SWEEP -> IDLE:
  - On the edge that writes lamp 15: counter wraps to 0, busy=0, done=1.
  - done is high for exactly one cycle, with state already IDLE; ready may be 1 in that same cycle.
- Sweep duration: busy high for exactly 16 cycles. Toggle via sweep inverts every lamp exactly once. Sweep with command 00 still takes 16 cycles and leaves lamps unchanged.
- Back-to-back: bcast asserted in the done cycle starts a new sweep immediately.
- Reset mid-sweep: the sweep is aborted and the reset values apply on that edge, with no done pulse.
- No X propagation: idx is always in range (4 bits map onto 16 lamps); no out-of-range case exists.

Test Plan:
- Reset then idle → lamps=0000, busy=0, done=0, ready=1.
- Single writes:
  - valid, idx=3, cmd=10 → next cycle lamps=0008.
  - idx=3, cmd=11 → lamps=0000.
  - idx=15, cmd=10 then idx=15, cmd=00 → lamps=8000 held.
- Sweep, on from empty:
  - lamps=0000, bcast=1 with bcast_cmd=10 → busy high 16 cycles.
  - lamps reads 0001, 0003, 0007, … FFFF, one bit per cycle.
  - done pulses once with lamps=FFFF; ready returns to 1.
- Sweep, toggle:
  - lamps=00F0, bcast with bcast_cmd=11 → lamps=FF0F after 16 cycles; done pulses once.
- Collisions:
  - Same cycle bcast=1 (bcast_cmd=01) and valid=1 (idx=0, cmd=10) from lamps=FFFF → ready=0 that cycle; single write dropped; final lamps=0000.
  - valid pulses during SWEEP have no effect.
- Reset mid-sweep:
  - bcast_cmd=10 from 0000; assert reset after 5 sweep cycles (lamps=001F) → next cycle lamps=0000, busy=0, and no done pulse.
  - A subsequent idx=2, cmd=10 write yields lamps=0004.

Source files
------------

// File: rtl/lamp_cmd_demux16_if.sv
// Command/status bundle between the selection logic and the lamp demux.
// Handshake: valid/ready for single-lamp writes; bcast starts a sweep.
interface lamp_cmd_demux16_if #(
  parameter int N_LAMPS = 16,
  parameter int IDX_W   = 4
);
  logic               valid;
  logic               ready;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         cmd;
  logic               bcast;
  logic [1:0]         bcast_cmd;
  logic [N_LAMPS-1:0] lamps;
  logic               busy;
  logic               done;

  modport master (
    output valid, idx, cmd, bcast, bcast_cmd,
    input  ready, lamps, busy, done
  );

  modport slave (
    input  valid, idx, cmd, bcast, bcast_cmd,
    output ready, lamps, busy, done
  );
endinterface

// File: rtl/lamp_cmd_demux16.sv
// 16-lamp command demux: applies single-lamp commands, or sweeps a latched
// broadcast command across all lamps one per clock.
module lamp_cmd_demux16 #(
  parameter int N_LAMPS = 16,
  parameter int IDX_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  lamp_cmd_demux16_if.slave bus
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LAMPS - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         bcmd_q, bcmd_d;
  logic [N_LAMPS-1:0] lamps_q, lamps_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // 00 hold, 01 clear, 10 set, 11 invert
  function automatic logic apply_cmd(input logic cur, input logic [1:0] c);
    case (c)
      2'b01:   apply_cmd = 1'b0;
      2'b10:   apply_cmd = 1'b1;
      2'b11:   apply_cmd = ~cur;
      default: apply_cmd = cur;
    endcase
  endfunction

  assign bus.ready = (state_q == IDLE) && !bus.bcast;
  assign bus.lamps = lamps_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcmd_d  = bcmd_q;
    lamps_d = lamps_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A broadcast request wins over a simultaneous single write.
        if (bus.bcast) begin
          state_d = SWEEP;
          bcmd_d  = bus.bcast_cmd;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (bus.valid) begin
          lamps_d[bus.idx] = apply_cmd(lamps_q[bus.idx], bus.cmd);
        end
      end
      SWEEP: begin
        lamps_d[cnt_q] = apply_cmd(lamps_q[cnt_q], bcmd_q);
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcmd_q  <= 2'b00;
      lamps_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcmd_q  <= bcmd_d;
      lamps_q <= lamps_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_lamp_cmd_demux16.sv
// Directed bench for lamp_cmd_demux16: single writes, sweeps, collisions,
// back-to-back broadcast and reset during a sweep.
module tb_lamp_cmd_demux16;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;

  lamp_cmd_demux16_if #(.N_LAMPS(16), .IDX_W(4)) bus ();

  lamp_cmd_demux16 #(.N_LAMPS(16), .IDX_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic single(input logic [3:0] i, input logic [1:0] c);
    bus.valid = 1'b1;
    bus.idx   = i;
    bus.cmd   = c;
    step();
    bus.valid = 1'b0;
    bus.cmd   = 2'b00;
  endtask

  initial begin
    logic [15:0] exp_l;
    n_cmp  = 0;
    n_fail = 0;
    reset         = 1'b1;
    bus.valid     = 1'b0;
    bus.idx       = '0;
    bus.cmd       = 2'b00;
    bus.bcast     = 1'b0;
    bus.bcast_cmd = 2'b00;
    step();
    step();
    reset = 1'b0;
    check("rst_lamps", 32'(bus.lamps), 32'h0000);
    check("rst_busy",  32'(bus.busy),  32'h0);
    check("rst_done",  32'(bus.done),  32'h0);
    check("rst_ready", 32'(bus.ready), 32'h1);

    single(4'd3, 2'b10);
    check("wr3_on",  32'(bus.lamps), 32'h0008);
    single(4'd3, 2'b11);
    check("wr3_tog", 32'(bus.lamps), 32'h0000);
    single(4'd15, 2'b10);
    check("wr15_on", 32'(bus.lamps), 32'h8000);
    single(4'd15, 2'b00);
    check("wr15_nop", 32'(bus.lamps), 32'h8000);
    single(4'd15, 2'b01);
    check("wr15_off", 32'(bus.lamps), 32'h0000);

    // Sweep "on" from empty
    bus.bcast     = 1'b1;
    bus.bcast_cmd = 2'b10;
    #1;
    check("bc_ready0", 32'(bus.ready), 32'h0);
    step();
    bus.bcast = 1'b0;
    check("on_busy_entry", 32'(bus.busy), 32'h1);
    check("on_lamps_entry", 32'(bus.lamps), 32'h0000);
    for (int k = 0; k < 16; k++) begin
      step();
      exp_l = 16'((32'h1 << (k + 1)) - 1);
      check("on_lamps", 32'(bus.lamps), 32'(exp_l));
      check("on_busy",  32'(bus.busy),  (k < 15) ? 32'h1 : 32'h0);
      check("on_done",  32'(bus.done),  (k < 15) ? 32'h0 : 32'h1);
    end
    check("on_ready_done", 32'(bus.ready), 32'h1);
    step();
    check("on_done_clr", 32'(bus.done), 32'h0);

    // Collision: bcast clear + single write in the same cycle
    bus.bcast     = 1'b1;
    bus.bcast_cmd = 2'b01;
    bus.valid     = 1'b1;
    bus.idx       = 4'd0;
    bus.cmd       = 2'b10;
    #1;
    check("col_ready0", 32'(bus.ready), 32'h0);
    step();
    bus.bcast = 1'b0;
    bus.valid = 1'b0;
    check("col_busy", 32'(bus.busy), 32'h1);
    check("col_lamps_entry", 32'(bus.lamps), 32'hFFFF);
    for (int k = 0; k < 16; k++) step();
    check("col_lamps", 32'(bus.lamps), 32'h0000);
    check("col_done",  32'(bus.done),  32'h1);
    step();

    // Build 00F0, then toggle sweep with stray inputs held during the sweep
    for (int k = 4; k < 8; k++) single(4'(k), 2'b10);
    check("pre_tog", 32'(bus.lamps), 32'h00F0);
    bus.bcast     = 1'b1;
    bus.bcast_cmd = 2'b11;
    step();
    bus.bcast_cmd = 2'b01;
    bus.valid     = 1'b1;
    bus.idx       = 4'd0;
    bus.cmd       = 2'b10;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 7) check("tog_mid", 32'(bus.lamps), 32'h000F);
    end
    bus.valid = 1'b0;
    bus.bcast = 1'b0;
    check("tog_lamps", 32'(bus.lamps), 32'hFF0F);
    check("tog_done",  32'(bus.done),  32'h1);
    check("tog_busy",  32'(bus.busy),  32'h0);

    // Back-to-back: new sweep with command 00 requested in the done cycle
    bus.bcast     = 1'b1;
    bus.bcast_cmd = 2'b00;
    step();
    bus.bcast = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'h1);
    check("b2b_done_clr", 32'(bus.done), 32'h0);
    for (int k = 0; k < 15; k++) step();
    check("nop_busy_last", 32'(bus.busy), 32'h1);
    // Chain a clearing sweep from the done cycle of the no-op sweep
    bus.bcast     = 1'b1;
    bus.bcast_cmd = 2'b01;
    step();
    check("nop_lamps", 32'(bus.lamps), 32'hFF0F);
    check("nop_done",  32'(bus.done),  32'h1);
    step();
    bus.bcast = 1'b0;
    check("clr_busy", 32'(bus.busy), 32'h1);
    for (int k = 0; k < 16; k++) step();
    check("clr_lamps", 32'(bus.lamps), 32'h0000);
    check("clr_done",  32'(bus.done),  32'h1);
    step();

    // Reset during a sweep
    bus.bcast     = 1'b1;
    bus.bcast_cmd = 2'b10;
    step();
    bus.bcast = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("mid_lamps", 32'(bus.lamps), 32'h001F);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_lamps", 32'(bus.lamps), 32'h0000);
    check("mrst_busy",  32'(bus.busy),  32'h0);
    check("mrst_done",  32'(bus.done),  32'h0);
    for (int k = 0; k < 12; k++) begin
      step();
      check("mrst_no_done", 32'(bus.done), 32'h0);
    end
    single(4'd2, 2'b10);
    check("post_wr2", 32'(bus.lamps), 32'h0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
